// File: rtl/reexe_pipe_pkg.sv
// Shared widths and stage-record layout for the re-execute delay pipe.
// Record layout, LSB first: aluRes | VAddr | writeNum | valid.
package reexe_pipe_pkg;

  localparam int GPR_NUM_W     = 5;
  localparam int SINGLE_WORD_W = 32;

  function automatic int rec_w(input int num_w, input int data_w);
    return 1 + num_w + 2 * data_w;
  endfunction

  function automatic int off_vaddr(input int data_w);
    return data_w;
  endfunction

  function automatic int off_num(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int off_valid(input int num_w, input int data_w);
    return 2 * data_w + num_w;
  endfunction

endpackage

// File: rtl/reexe_stage.sv
// One delay stage: a record register that reloads when told to advance.
// An invalid incoming record is stored as all zeros so empty stages never show stale data.
module reexe_stage
  import reexe_pipe_pkg::*;
#(
  parameter int NUM_W  = GPR_NUM_W,
  parameter int DATA_W = SINGLE_WORD_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              adv,
  input  logic [rec_w(NUM_W, DATA_W)-1:0]   in_rec,
  output logic [rec_w(NUM_W, DATA_W)-1:0]   rec_q
);

  localparam int OFF_VALID = off_valid(NUM_W, DATA_W);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rec_q <= '0;
    end else if (adv) begin
      rec_q <= in_rec[OFF_VALID] ? in_rec : '0;
    end
  end

endmodule

// File: rtl/reexe_pipe.sv
// DEPTH-stage delay pipe between SBA and MEM with bubble collapse and flush.
// Build with REEXE_PIPE_LOOKUP_EN to enable the writeNum forwarding lookup port.
module reexe_pipe
  import reexe_pipe_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = SINGLE_WORD_W,
  parameter int NUM_W  = GPR_NUM_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    SBA_valid_w_i,
  input  logic [NUM_W-1:0]        SBA_writeNum_i,
  input  logic [DATA_W-1:0]       SBA_VAddr_i,
  input  logic [DATA_W-1:0]       SBA_aluRes_i,
  input  logic                    flush_w_i,
  input  logic                    MEM_allowin_w_i,
  output logic                    REEXE_okToChange_w_o,
  output logic                    REEXE_valid_w_o,
  output logic [NUM_W-1:0]        REEXE_writeNum_o,
  output logic [DATA_W-1:0]       REEXE_VAddr_o,
  output logic [DATA_W-1:0]       REEXE_regData_o,
  output logic [DEPTH-1:0]        REEXE_stgValid_w_o,
  output logic [DEPTH*NUM_W-1:0]  REEXE_stgWriteNum_w_o,
  input  logic [NUM_W-1:0]        lkNum_w_i,
  output logic                    lkHit_w_o,
  output logic [DATA_W-1:0]       lkData_w_o
);

  localparam int REC_W     = rec_w(NUM_W, DATA_W);
  localparam int OFF_VADDR = off_vaddr(DATA_W);
  localparam int OFF_NUM   = off_num(DATA_W);
  localparam int OFF_VALID = off_valid(NUM_W, DATA_W);

  logic [REC_W-1:0] rec    [DEPTH];
  logic [REC_W-1:0] stg_in [DEPTH];
  logic [DEPTH-1:0] stg_valid;
  logic [DEPTH-1:0] adv;
  logic             push;

  // Stage k moves when the stage after it is empty or itself moving.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = MEM_allowin_w_i || !stg_valid[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = !stg_valid[k+1] || adv[k+1];
    end
  end

  assign REEXE_okToChange_w_o = adv[0];
  assign push                 = SBA_valid_w_i && adv[0];
  assign stg_in[0]            = {push, SBA_writeNum_i, SBA_VAddr_i, SBA_aluRes_i};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    if (k > 0) begin : g_chain
      assign stg_in[k] = rec[k-1];
    end

    reexe_stage #(
      .NUM_W  (NUM_W),
      .DATA_W (DATA_W)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush_w_i),
      .adv    (adv[k]),
      .in_rec (stg_in[k]),
      .rec_q  (rec[k])
    );

    assign stg_valid[k]                          = rec[k][OFF_VALID];
    assign REEXE_stgWriteNum_w_o[k*NUM_W +: NUM_W] = rec[k][OFF_NUM +: NUM_W];
  end

  assign REEXE_stgValid_w_o = stg_valid;
  assign REEXE_valid_w_o    = stg_valid[DEPTH-1];
  assign REEXE_writeNum_o   = rec[DEPTH-1][OFF_NUM +: NUM_W];
  assign REEXE_VAddr_o      = rec[DEPTH-1][OFF_VADDR +: DATA_W];
  assign REEXE_regData_o    = rec[DEPTH-1][DATA_W-1:0];

`ifdef REEXE_PIPE_LOOKUP_EN
  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    lkHit_w_o  = 1'b0;
    lkData_w_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (lkNum_w_i != '0 && stg_valid[k] && rec[k][OFF_NUM +: NUM_W] == lkNum_w_i) begin
        lkHit_w_o  = 1'b1;
        lkData_w_o = rec[k][DATA_W-1:0];
      end
    end
  end
`else
  logic unused_lk_num;
  assign unused_lk_num = ^lkNum_w_i;
  assign lkHit_w_o     = 1'b0;
  assign lkData_w_o    = '0;
`endif

endmodule

// File: tb/tb_reexe_pipe.sv
// Self-checking bench: a DEPTH=2 and a DEPTH=3 pipe share stimulus, each tracked by a slot model.
module tb_reexe_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sba_valid = 1'b0;
  logic [4:0]  sba_num = '0;
  logic [31:0] sba_va = '0;
  logic [31:0] sba_alu = '0;
  logic        flush = 1'b0;
  logic        allow = 1'b0;
  logic [4:0]  lk_num = '0;

  logic        ok2, v2, hit2;
  logic [4:0]  n2;
  logic [31:0] va2, rd2, lkd2;
  logic [1:0]  sv2;
  logic [9:0]  sn2;

  logic        ok3, v3, hit3;
  logic [4:0]  n3;
  logic [31:0] va3, rd3, lkd3;
  logic [2:0]  sv3;
  logic [14:0] sn3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reexe_pipe #(.DEPTH(2), .DATA_W(32), .NUM_W(5)) dut2 (
    .clk(clk), .rst(rst), .SBA_valid_w_i(sba_valid), .SBA_writeNum_i(sba_num),
    .SBA_VAddr_i(sba_va), .SBA_aluRes_i(sba_alu), .flush_w_i(flush), .MEM_allowin_w_i(allow),
    .REEXE_okToChange_w_o(ok2), .REEXE_valid_w_o(v2), .REEXE_writeNum_o(n2),
    .REEXE_VAddr_o(va2), .REEXE_regData_o(rd2), .REEXE_stgValid_w_o(sv2),
    .REEXE_stgWriteNum_w_o(sn2), .lkNum_w_i(lk_num), .lkHit_w_o(hit2), .lkData_w_o(lkd2));

  reexe_pipe #(.DEPTH(3), .DATA_W(32), .NUM_W(5)) dut3 (
    .clk(clk), .rst(rst), .SBA_valid_w_i(sba_valid), .SBA_writeNum_i(sba_num),
    .SBA_VAddr_i(sba_va), .SBA_aluRes_i(sba_alu), .flush_w_i(flush), .MEM_allowin_w_i(allow),
    .REEXE_okToChange_w_o(ok3), .REEXE_valid_w_o(v3), .REEXE_writeNum_o(n3),
    .REEXE_VAddr_o(va3), .REEXE_regData_o(rd3), .REEXE_stgValid_w_o(sv3),
    .REEXE_stgWriteNum_w_o(sn3), .lkNum_w_i(lk_num), .lkHit_w_o(hit3), .lkData_w_o(lkd3));

  // Model: slot 0 youngest; index d=0 is the DEPTH=2 pipe, d=1 the DEPTH=3 pipe.
  typedef struct packed {
    logic        v;
    logic [4:0]  n;
    logic [31:0] va;
    logic [31:0] alu;
  } slot_t;

  slot_t m [2][8];

  function automatic logic [7:0] model_adv(input int d);
    logic [7:0] a;
    int dep;
    dep = d + 2;
    a = '0;
    a[dep-1] = allow || !m[d][dep-1].v;
    for (int k = dep - 2; k >= 0; k--) a[k] = !m[d][k+1].v || a[k+1];
    return a;
  endfunction

  function automatic void model_step(input int d);
    logic [7:0] a;
    int dep;
    dep = d + 2;
    a = model_adv(d);
    if (rst || flush) begin
      for (int k = 0; k < 8; k++) m[d][k] = '0;
    end else begin
      for (int k = dep - 1; k >= 0; k--) begin
        if (a[k]) begin
          if (k == 0) m[d][0] = sba_valid ? {1'b1, sba_num, sba_va, sba_alu} : '0;
          else        m[d][k] = m[d][k-1];
        end
      end
    end
  endfunction

  function automatic logic [151:0] exp_vec(input int d);
    logic [7:0]  a, sv;
    logic [39:0] sn;
    logic        hit;
    logic [31:0] data;
    int dep;
    slot_t top;
    dep = d + 2;
    a = model_adv(d);
    top = m[d][dep-1];
    sv = '0;
    sn = '0;
    hit = 1'b0;
    data = '0;
    for (int k = 0; k < dep; k++) begin
      sv[k] = m[d][k].v;
      sn[k*5 +: 5] = m[d][k].n;
    end
`ifdef REEXE_PIPE_LOOKUP_EN
    for (int k = 0; k < dep; k++) begin
      if (!hit && lk_num != 0 && m[d][k].v && m[d][k].n == lk_num) begin
        hit = 1'b1;
        data = m[d][k].alu;
      end
    end
`endif
    return {a[0], top.v, top.n, top.va, top.alu, sv, sn, hit, data};
  endfunction

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sba_valid = 1'b0; sba_num = '0; sba_va = '0; sba_alu = '0;
    flush = 1'b0; lk_num = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic push(input logic [4:0] num, input logic [31:0] alu);
    sba_valid = 1'b1; sba_num = num; sba_va = 32'h1000 + alu; sba_alu = alu;
  endtask

  task automatic test_reset();
    idle_inputs();
    allow = 1'b0;
    rst = 1'b1;
    cycle();
    cycle();
    #1;
    n_checks++; if ({v2, rd2, n2, va2, sv2} !== '0) $display("FAIL reset_outputs2 got=%h exp=0", {v2, rd2, n2, va2, sv2}); else n_pass++;
    n_checks++; if ({v3, sv3, sn3, hit3, lkd3} !== '0) $display("FAIL reset_outputs3 got=%h exp=0", {v3, sv3, sn3, hit3, lkd3}); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (ok3 !== 1'b1 || ok2 !== 1'b1) $display("FAIL reset_ok got=%b%b exp=11", ok2, ok3); else n_pass++;
  endtask

  task automatic test_latency();
    logic exp_hit;
    logic [31:0] exp_d;
`ifdef REEXE_PIPE_LOOKUP_EN
    exp_hit = 1'b1; exp_d = 32'h11;
`else
    exp_hit = 1'b0; exp_d = 32'h0;
`endif
    do_reset();
    allow = 1'b1;
    push(5'd3, 32'h11);
    cycle();
    idle_inputs();
    lk_num = 5'd3;
    #1;
    n_checks++; if (v2 !== 1'b0) $display("FAIL lat_early got=%b exp=0", v2); else n_pass++;
    n_checks++; if ({hit2, lkd2} !== {exp_hit, exp_d}) $display("FAIL lat_lookup got=%b/%h exp=%b/%h", hit2, lkd2, exp_hit, exp_d); else n_pass++;
    cycle();
    n_checks++; if ({v2, n2, rd2} !== {1'b1, 5'd3, 32'h11}) $display("FAIL lat_d2 got=%b/%0d/%h exp=1/3/11", v2, n2, rd2); else n_pass++;
    n_checks++; if (v3 !== 1'b0) $display("FAIL lat_d3_early got=%b exp=0", v3); else n_pass++;
    cycle();
    n_checks++; if ({v2, rd2} !== 33'h0) $display("FAIL lat_d2_after got=%b/%h exp=0/0", v2, rd2); else n_pass++;
    n_checks++; if ({v3, rd3} !== {1'b1, 32'h11}) $display("FAIL lat_d3 got=%b/%h exp=1/11", v3, rd3); else n_pass++;
    lk_num = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    allow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(5'(i + 1), 32'h20 + 32'(i));
      #1;
      n_checks++; if (ok3 !== (i < 3)) $display("FAIL bp_ok%0d got=%b exp=%b", i, ok3, (i < 3)); else n_pass++;
      cycle();
    end
    idle_inputs();
    allow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({v3, rd3} !== {1'b1, 32'h20 + 32'(i)}) $display("FAIL bp_out%0d got=%b/%h exp=1/%h", i, v3, rd3, 32'h20 + 32'(i)); else n_pass++;
      cycle();
    end
    n_checks++; if (v3 !== 1'b0) $display("FAIL bp_drained got=%b exp=0", v3); else n_pass++;
  endtask

  task automatic test_lookup();
    logic exp_hit;
    logic [31:0] exp_d;
`ifdef REEXE_PIPE_LOOKUP_EN
    exp_hit = 1'b1; exp_d = 32'hB;
`else
    exp_hit = 1'b0; exp_d = 32'h0;
`endif
    do_reset();
    allow = 1'b0;
    push(5'd5, 32'hA);
    cycle();
    push(5'd5, 32'hB);
    cycle();
    idle_inputs();
    lk_num = 5'd5;
    #1;
    n_checks++; if ({hit2, lkd2} !== {exp_hit, exp_d}) $display("FAIL lk_young2 got=%b/%h exp=%b/%h", hit2, lkd2, exp_hit, exp_d); else n_pass++;
    n_checks++; if ({hit3, lkd3} !== {exp_hit, exp_d}) $display("FAIL lk_young3 got=%b/%h exp=%b/%h", hit3, lkd3, exp_hit, exp_d); else n_pass++;
    lk_num = 5'd0;
    #1;
    n_checks++; if ({hit2, lkd2} !== 33'h0) $display("FAIL lk_zero got=%b/%h exp=0/0", hit2, lkd2); else n_pass++;
    lk_num = 5'd6;
    #1;
    n_checks++; if ({hit3, lkd3} !== 33'h0) $display("FAIL lk_miss got=%b/%h exp=0/0", hit3, lkd3); else n_pass++;
    lk_num = '0;
  endtask

  task automatic test_flush();
    do_reset();
    allow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(5'(i + 7), 32'h40 + 32'(i));
      cycle();
    end
    push(5'd9, 32'h99);
    flush = 1'b1;
    allow = 1'b1;
    cycle();
    idle_inputs();
    #1;
    n_checks++; if ({sv2, sv3, v3} !== '0) $display("FAIL flush_valid got=%b/%b exp=0", sv2, sv3); else n_pass++;
    n_checks++; if ({sn2, sn3} !== '0) $display("FAIL flush_nums got=%h/%h exp=0", sn2, sn3); else n_pass++;
    cycle();
    cycle();
    n_checks++; if ({sv2, sv3, v2, v3} !== '0) $display("FAIL flush_nocapture got=%b/%b exp=0", sv2, sv3); else n_pass++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    allow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(5'(i + 1), 32'h60 + 32'(i));
      cycle();
    end
    rst = 1'b1;
    allow = 1'b1;
    cycle();
    rst = 1'b0;
    idle_inputs();
    lk_num = 5'd1;
    #1;
    n_checks++; if ({v3, n3, va3, rd3, sv3, sn3, hit3, lkd3} !== '0) $display("FAIL rst_mid_out got=%b/%h exp=0", v3, rd3); else n_pass++;
    n_checks++; if (ok3 !== 1'b1) $display("FAIL rst_mid_ok got=%b exp=1", ok3); else n_pass++;
    lk_num = '0;
  endtask

  task automatic test_random();
    logic [151:0] got, exp;
    int bad2, bad3;
    bad2 = 0;
    bad3 = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      sba_valid = ($urandom_range(0, 9) < 6);
      sba_num   = 5'($urandom_range(0, 7));
      sba_va    = $urandom;
      sba_alu   = $urandom;
      allow     = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      lk_num    = 5'($urandom_range(0, 7));
      #1;
      got = {ok2, v2, n2, va2, rd2, 8'(sv2), 40'(sn2), hit2, lkd2};
      exp = exp_vec(0);
      n_checks++;
      if (got !== exp) begin
        if (bad2 < 5) $display("FAIL rand_d2 cycle=%0d got=%h exp=%h", c, got, exp);
        bad2++;
      end else n_pass++;
      got = {ok3, v3, n3, va3, rd3, 8'(sv3), 40'(sn3), hit3, lkd3};
      exp = exp_vec(1);
      n_checks++;
      if (got !== exp) begin
        if (bad3 < 5) $display("FAIL rand_d3 cycle=%0d got=%h exp=%h", c, got, exp);
        bad3++;
      end else n_pass++;
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) m[d][k] = '0;
    test_reset();
    test_latency();
    test_backpressure();
    test_lookup();
    test_flush();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reexe_pipe.md
REEXE_PIPE -- requirements
Module: reexe_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of delay stages (legal 1..8).
REQ-002 SHALL have parameter DATA_W, default 32, result/VAddr width.
REQ-003 SHALL have parameter NUM_W, default 5, GPR number width; writeNum 0 means no writeback.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 SBA_valid_w_i  in  1  upstream has an instruction.
REQ-007 SBA_writeNum_i  in  NUM_W; SBA_VAddr_i  in  DATA_W; SBA_aluRes_i  in  DATA_W  upstream payload.
REQ-008 flush_w_i  in  1  kill all held instructions.
REQ-009 MEM_allowin_w_i  in  1  downstream accepts this cycle.
REQ-010 REEXE_okToChange_w_o  out  1  stage 0 accepts this cycle.
REQ-011 REEXE_valid_w_o  out  1  last stage holds an instruction.
REQ-012 REEXE_writeNum_o  out  NUM_W; REEXE_VAddr_o  out  DATA_W; REEXE_regData_o  out  DATA_W  last-stage payload.
REQ-013 REEXE_stgValid_w_o  out  DEPTH; REEXE_stgWriteNum_w_o  out  DEPTH*NUM_W  per-stage forwarding view, stage 0 in LSBs.
REQ-014 lkNum_w_i  in  NUM_W; lkHit_w_o  out  1; lkData_w_o  out  DATA_W  forwarding lookup port.

Function
REQ-015 Stage k SHALL hold valid bit + writeNum + VAddr + aluRes; stage 0 youngest, stage DEPTH-1 oldest.
REQ-016 Last stage SHALL advance when MEM_allowin_w_i or empty; stage k<DEPTH-1 SHALL advance when stage k+1 is empty or advancing (bubble collapse).
REQ-017 REEXE_okToChange_w_o SHALL equal stage-0 advance condition, combinational.
REQ-018 Upstream transfer SHALL occur when SBA_valid_w_i && REEXE_okToChange_w_o; data enters stage 0 next cycle.
REQ-019 Advancing stage with no incoming data SHALL become empty (valid=0, payload zeroed).
REQ-020 Downstream transfer SHALL occur when REEXE_valid_w_o && MEM_allowin_w_i.
REQ-021 Minimum latency SHALL be DEPTH cycles input-to-REEXE_valid_w_o with MEM_allowin_w_i held high.
REQ-022 Full pipe with MEM_allowin_w_i high SHALL accept and emit one instruction per cycle.
REQ-023 flush_w_i SHALL clear every stage next cycle and block that cycle's upstream transfer; flush wins over simultaneous push/pop.
REQ-024 lkHit_w_o SHALL be 1 when lkNum_w_i != 0 and a valid stage has equal writeNum; lkData_w_o SHALL be aluRes of the youngest such stage, else 0.
REQ-025 Lookup SHALL be combinational over registered state only; no path from lkNum_w_i to handshake outputs.
REQ-026 Empty stages' payload SHALL read 0 so per-stage views never show stale numbers.

Reset
REQ-027 rst SHALL clear all valid bits and payloads on the clock edge; REEXE_valid_w_o=0, outputs 0, lkHit_w_o=0.
REQ-028 rst mid-operation SHALL discard all held instructions; no transfer reported that cycle.
REQ-029 REEXE_okToChange_w_o SHALL be 1 in the first cycle after reset.

Configuration
REQ-030 Macro REEXE_PIPE_LOOKUP_EN: defined -> REQ-024/025 lookup logic present.
REQ-031 Undefined -> lkHit_w_o and lkData_w_o tied 0, lkNum_w_i ignored; pipeline behaviour otherwise identical.

Structure
REQ-032 Shared defines file SHALL hold GPR_NUM / SINGLE_WORD widths and stage record field layout; no module-local copies.
REQ-033 One sub-module reexe_stage (one stage register + valid + advance logic) SHALL be generated DEPTH times; lookup priority mux in top level.

Verification
REQ-034 DEPTH=2, push {num=3,alu=0x11} at cycle 0, MEM_allowin=1 -> REEXE_valid_w_o=1, regData=0x11 at cycle 2, then 0.
REQ-035 DEPTH=3, MEM_allowin=0, push 4 back-to-back -> 3 accepted, okToChange=0 on 4th; release -> outputs in order, one per cycle.
REQ-036 Stages hold num=5 alu=0xA (older) and num=5 alu=0xB (younger), lkNum=5 -> lkHit=1, lkData=0xB; lkNum=0 -> lkHit=0.
REQ-037 Full pipe, flush_w_i with simultaneous SBA_valid_w_i and MEM_allowin -> next cycle all stgValid=0, new data not captured.
REQ-038 rst asserted with full pipe -> next cycle all outputs 0, okToChange=1.
REQ-039 Build without REEXE_PIPE_LOOKUP_EN, matching num held -> lkHit=0, lkData=0, REQ-034 result unchanged.
